// File: rtl/obi_frame_mem_if.sv
// obi_frame_mem_if
// ----------------
// OBI request/response bundle between a manager and the frame memory.
//
// Signals:
//   req     manager -> memory  request valid
//   addr    manager -> memory  byte address
//   we      manager -> memory  1 = write, 0 = read
//   be      manager -> memory  byte enables for writes
//   wdata   manager -> memory  write data
//   aid     manager -> memory  transaction id, echoed back on rid
//   gnt     memory -> manager  request accepted this cycle
//   rvalid  memory -> manager  response valid (one cycle after gnt)
//   rdata   memory -> manager  read data (0 for writes)
//   rid     memory -> manager  echoed aid
//   err     memory -> manager  error response
interface obi_frame_mem_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [3:0]  aid;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [3:0]  rid;
  logic        err;

  modport master (
    output req, addr, we, be, wdata, aid,
    input  gnt, rvalid, rdata, rid, err
  );

  modport slave (
    input  req, addr, we, be, wdata, aid,
    output gnt, rvalid, rdata, rid, err
  );
endinterface

// File: rtl/obi_frame_mem.sv
// obi_frame_mem
// -------------
// OBI subordinate frame memory: a flop-based array of NumWords 32-bit words
// with byte-enable writes, a programmable number of wait states before each
// grant, and saturating read/write access counters for bandwidth debug.
//
// Parameters:
//   NumWords    number of 32-bit words (power of two, >= 4)
//   WaitCycles  cycles a request stays ungranted before gnt (0..15)
//   CntWidth    width of the access counters
//
// Ports:
//   clk_i     clock
//   rst_ni    asynchronous active-low reset
//   obi       OBI subordinate port (obi_frame_mem_if.slave)
//   rd_cnt_o  granted reads, saturating at all-ones
//   wr_cnt_o  granted writes, saturating at all-ones
//   busy_o    request pending or response in flight
//
// Optional feature (macro OBI_FRAME_MEM_ERR_EN):
//   Defined   - accesses with address bits above the word index set are
//               granted but answered with err=1 (reads return 32'hBADCAB1E)
//               and do not touch memory or counters.
//   Undefined - upper address bits are ignored (aliasing) and err is 0.
module obi_frame_mem #(
  parameter int NumWords   = 64,
  parameter int WaitCycles = 1,
  parameter int CntWidth   = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  obi_frame_mem_if.slave      obi,
  output logic [CntWidth-1:0] rd_cnt_o,
  output logic [CntWidth-1:0] wr_cnt_o,
  output logic                busy_o
);

  localparam int          IdxWidth = $clog2(NumWords);
  localparam logic [3:0]  WaitLast = 4'(WaitCycles);
  localparam logic [31:0] ErrData  = 32'hBADCAB1E;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    GRANT = 2'd2
  } state_e;

  state_e                state;
  logic [3:0]            wait_cnt;
  logic [31:0]           mem [NumWords];
  logic [IdxWidth-1:0]   idx;
  logic                  gnt;
  logic                  out_of_range;
  logic                  do_read;
  logic                  do_write;
  logic                  rvalid_q;
  logic [31:0]           rdata_q;
  logic [3:0]            rid_q;

  assign idx = obi.addr[2 +: IdxWidth];

`ifdef OBI_FRAME_MEM_ERR_EN
  logic err_q;
  logic unused_addr_bits;

  assign out_of_range     = |obi.addr[31:2+IdxWidth];
  assign unused_addr_bits = ^obi.addr[1:0];
  assign obi.err          = err_q;
`else
  logic unused_addr_bits;

  assign out_of_range     = 1'b0;
  assign unused_addr_bits = ^{obi.addr[31:2+IdxWidth], obi.addr[1:0]};
  assign obi.err          = 1'b0;
`endif

  // With zero wait states the grant is a pure function of req so the
  // manager can stream one transfer per cycle; otherwise only GRANT answers.
  assign gnt      = obi.req & ((WaitCycles == 0) | (state == GRANT));
  assign do_read  = gnt & ~obi.we & ~out_of_range;
  assign do_write = gnt &  obi.we & ~out_of_range;

  assign obi.gnt    = gnt;
  assign obi.rvalid = rvalid_q;
  assign obi.rdata  = rdata_q;
  assign obi.rid    = rid_q;
  assign busy_o     = obi.req | rvalid_q;

  // wait_cnt holds the number of stall cycles already served, so the cycle
  // that takes it to WaitCycles is the last ungranted one and the next
  // cycle grants. Any drop of req abandons the request without side effects.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (obi.req && (WaitCycles != 0)) begin
            wait_cnt <= 4'd1;
            state    <= (WaitLast == 4'd1) ? GRANT : STALL;
          end
        end
        STALL: begin
          if (!obi.req) begin
            wait_cnt <= 4'd0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
            if (wait_cnt + 4'd1 == WaitLast) begin
              state <= GRANT;
            end
          end
        end
        GRANT: begin
          wait_cnt <= 4'd0;
          state    <= IDLE;
        end
        default: begin
          wait_cnt <= 4'd0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Storage is not reset so its contents survive a mid-transaction reset.
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (obi.be[b]) begin
          mem[idx][8*b +: 8] <= obi.wdata[8*b +: 8];
        end
      end
    end
  end

  // Response registers: rvalid follows gnt by exactly one cycle; rdata and
  // rid only change on a grant and otherwise hold their last value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      rid_q    <= 4'd0;
    end else begin
      rvalid_q <= gnt;
      if (gnt) begin
        rid_q <= obi.aid;
        if (obi.we) begin
          rdata_q <= 32'd0;
        end else if (out_of_range) begin
          rdata_q <= ErrData;
        end else begin
          rdata_q <= mem[idx];
        end
      end
    end
  end

`ifdef OBI_FRAME_MEM_ERR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (gnt) begin
      err_q <= out_of_range;
    end
  end
`endif

  // Counters stop at all-ones so a long debug run never reports a wrapped,
  // misleadingly small bandwidth figure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else begin
      if (do_read && (rd_cnt_o != '1)) begin
        rd_cnt_o <= rd_cnt_o + 1'b1;
      end
      if (do_write && (wr_cnt_o != '1)) begin
        wr_cnt_o <= wr_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_obi_frame_mem.sv
// tb_obi_frame_mem
// ----------------
// Scoreboard bench for obi_frame_mem. Three instances are exercised:
//   dut 0: WaitCycles=1, CntWidth=16  (main functional sequence, reset)
//   dut 1: WaitCycles=0, CntWidth=2   (streaming, counter saturation)
//   dut 2: WaitCycles=3, CntWidth=16  (abort in STALL, long wait)
// Stimulus pushes the expected response at grant time; per-instance
// monitors pop and compare whenever rvalid is seen.
// Honors OBI_FRAME_MEM_ERR_EN for the out-of-range expectations.
module tb_obi_frame_mem;

  typedef struct {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] rd_cnt_a, wr_cnt_a, rd_cnt_c, wr_cnt_c;
  logic [1:0]  rd_cnt_b, wr_cnt_b;
  logic        busy_a, busy_b, busy_c;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  obi_frame_mem_if bus_a ();
  obi_frame_mem_if bus_b ();
  obi_frame_mem_if bus_c ();

  obi_frame_mem #(.NumWords(64), .WaitCycles(1), .CntWidth(16)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .obi(bus_a.slave),
    .rd_cnt_o(rd_cnt_a), .wr_cnt_o(wr_cnt_a), .busy_o(busy_a)
  );

  obi_frame_mem #(.NumWords(64), .WaitCycles(0), .CntWidth(2)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .obi(bus_b.slave),
    .rd_cnt_o(rd_cnt_b), .wr_cnt_o(wr_cnt_b), .busy_o(busy_b)
  );

  obi_frame_mem #(.NumWords(64), .WaitCycles(3), .CntWidth(16)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .obi(bus_c.slave),
    .rd_cnt_o(rd_cnt_c), .wr_cnt_o(wr_cnt_c), .busy_o(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkResponse(input int g, input logic [31:0] rdata,
                               input logic [3:0] rid, input logic err);
    exp_t e;
    int   sz;
    sz = (g == 0) ? q_a.size() : (g == 1) ? q_b.size() : q_c.size();
    n_vec++;
    if (sz == 0) begin
      n_err++;
      $display("[TB] FAIL unexpected_rvalid dut%0d: got rdata=0x%08h rid=%0d, expected no response",
               g, rdata, rid);
      return;
    end
    case (g)
      0:       e = q_a.pop_front();
      1:       e = q_b.pop_front();
      default: e = q_c.pop_front();
    endcase
    if ({rdata, rid, err} !== {e.rdata, e.rid, e.err}) begin
      n_err++;
      $display("[TB] FAIL response dut%0d: got rdata=0x%08h rid=%0d err=%0b, expected rdata=0x%08h rid=%0d err=%0b",
               g, rdata, rid, err, e.rdata, e.rid, e.err);
    end
    n_vec++;
    if (cyc != e.cyc) begin
      n_err++;
      $display("[TB] FAIL rvalid_timing dut%0d: got cycle %0d, expected cycle %0d", g, cyc, e.cyc);
    end
  endtask

  always @(negedge clk) if (bus_a.rvalid) checkResponse(0, bus_a.rdata, bus_a.rid, bus_a.err);
  always @(negedge clk) if (bus_b.rvalid) checkResponse(1, bus_b.rdata, bus_b.rid, bus_b.err);
  always @(negedge clk) if (bus_c.rvalid) checkResponse(2, bus_c.rdata, bus_c.rid, bus_c.err);

  task automatic drive(input int g, input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata, input logic [3:0] aid);
    case (g)
      0: begin
        bus_a.req = req; bus_a.we = we; bus_a.addr = addr;
        bus_a.be = be; bus_a.wdata = wdata; bus_a.aid = aid;
      end
      1: begin
        bus_b.req = req; bus_b.we = we; bus_b.addr = addr;
        bus_b.be = be; bus_b.wdata = wdata; bus_b.aid = aid;
      end
      default: begin
        bus_c.req = req; bus_c.we = we; bus_c.addr = addr;
        bus_c.be = be; bus_c.wdata = wdata; bus_c.aid = aid;
      end
    endcase
  endtask

  function automatic logic readGnt(input int g);
    case (g)
      0:       return bus_a.gnt;
      1:       return bus_b.gnt;
      default: return bus_c.gnt;
    endcase
  endfunction

  // Presents one request, waits (bounded) for the grant, checks the number
  // of ungranted cycles, queues the expected response and returns on the
  // granting edge with req still asserted, so calls can run back to back.
  task automatic applyStimulus(input int g, input logic we, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wdata,
                               input logic [3:0] aid, input logic [31:0] exp_rdata,
                               input logic exp_err, input int exp_wait);
    int   waited;
    logic got;
    exp_t e;
    waited = 0;
    @(negedge clk);
    drive(g, 1'b1, we, addr, be, wdata, aid);
    #1;
    got = readGnt(g);
    while (!got && waited < 20) begin
      @(negedge clk);
      waited++;
      #1;
      got = readGnt(g);
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("[TB] FAIL gnt_timeout dut%0d addr 0x%08h: got no gnt in 20 cycles, expected gnt", g, addr);
      return;
    end
    if (waited != exp_wait) begin
      n_err++;
      $display("[TB] FAIL gnt_latency dut%0d addr 0x%08h: got %0d wait cycles, expected %0d",
               g, addr, waited, exp_wait);
    end
    e.rdata = exp_rdata;
    e.rid   = aid;
    e.err   = exp_err;
    e.cyc   = cyc + 1;
    case (g)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
    @(posedge clk);
  endtask

  task automatic endReq(input int g);
    @(negedge clk);
    drive(g, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 4'd0);
  endtask

  logic [31:0] alias_rdata;
  logic        alias_err;
  logic [15:0] alias_rd_cnt;

  initial begin
`ifdef OBI_FRAME_MEM_ERR_EN
    alias_rdata  = 32'hBADCAB1E;
    alias_err    = 1'b1;
    alias_rd_cnt = 16'd3;
`else
    alias_rdata  = 32'h11112222;
    alias_err    = 1'b0;
    alias_rd_cnt = 16'd4;
`endif
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) drive(g, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 4'd0);
    repeat (3) @(negedge clk);
    checkOutput("reset_rvalid_a", {31'd0, bus_a.rvalid}, 32'd0);
    checkOutput("reset_rdata_a", bus_a.rdata, 32'd0);
    checkOutput("reset_rid_err_a", {27'd0, bus_a.rid, bus_a.err}, 32'd0);
    checkOutput("reset_cnt_a", {rd_cnt_a, wr_cnt_a}, 32'd0);
    checkOutput("reset_busy", {29'd0, busy_a, busy_b, busy_c}, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_gnt", {29'd0, bus_a.gnt, bus_b.gnt, bus_c.gnt}, 32'd0);

    $display("[TB] dut0: write/read with one wait state");
    applyStimulus(0, 1'b1, 32'h08, 4'hF, 32'hDEADBEEF, 4'd3, 32'd0, 1'b0, 1);
    endReq(0);
    checkOutput("wr_cnt_a_1", {16'd0, wr_cnt_a}, 32'd1);
    applyStimulus(0, 1'b0, 32'h08, 4'h0, 32'd0, 4'd5, 32'hDEADBEEF, 1'b0, 1);
    endReq(0);
    checkOutput("rd_cnt_a_1", {16'd0, rd_cnt_a}, 32'd1);
    applyStimulus(0, 1'b1, 32'h08, 4'b0010, 32'h00005500, 4'd1, 32'd0, 1'b0, 1);
    applyStimulus(0, 1'b0, 32'h08, 4'h0, 32'd0, 4'd2, 32'hDEAD55EF, 1'b0, 1);
    applyStimulus(0, 1'b1, 32'h00, 4'hF, 32'h11112222, 4'd4, 32'd0, 1'b0, 1);
    applyStimulus(0, 1'b1, 32'h0B, 4'h0, 32'hFFFFFFFF, 4'd6, 32'd0, 1'b0, 1);
    applyStimulus(0, 1'b0, 32'h09, 4'h0, 32'd0, 4'd8, 32'hDEAD55EF, 1'b0, 1);
    endReq(0);
    applyStimulus(0, 1'b0, 32'h100, 4'h0, 32'd0, 4'd9, alias_rdata, alias_err, 1);
    endReq(0);
    checkOutput("wr_cnt_a_4", {16'd0, wr_cnt_a}, 32'd4);
    checkOutput("rd_cnt_a_alias", {16'd0, rd_cnt_a}, {16'd0, alias_rd_cnt});

    $display("[TB] dut1: zero wait states, streaming and saturation");
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1'b1, 32'(4*i), 4'hF, 32'(i+1), 4'(i), 32'd0, 1'b0, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1'b0, 32'(4*i), 4'h0, 32'd0, 4'(8+i), 32'(i+1), 1'b0, 0);
    applyStimulus(1, 1'b1, 32'h10, 4'hF, 32'hCAFEF00D, 4'd12, 32'd0, 1'b0, 0);
    applyStimulus(1, 1'b0, 32'h10, 4'h0, 32'd0, 4'd13, 32'hCAFEF00D, 1'b0, 0);
    endReq(1);
    checkOutput("cnt_b_saturated", {28'd0, rd_cnt_b, wr_cnt_b}, 32'hF);

    $display("[TB] dut2: abort during stall, then three wait states");
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 32'h04, 4'h0, 32'd0, 4'd1);
    #1;
    checkOutput("abort_gnt_c0", {31'd0, bus_c.gnt}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("abort_gnt_c1_busy", {30'd0, bus_c.gnt, busy_c}, 32'd1);
    drive(2, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 4'd0);
    repeat (3) @(negedge clk);
    checkOutput("abort_cnt_c", {rd_cnt_c, wr_cnt_c}, 32'd0);
    checkOutput("abort_busy_c", {31'd0, busy_c}, 32'd0);
    applyStimulus(2, 1'b1, 32'h04, 4'hF, 32'hA5A5A5A5, 4'd7, 32'd0, 1'b0, 3);
    endReq(2);
    applyStimulus(2, 1'b0, 32'h04, 4'h0, 32'd0, 4'd14, 32'hA5A5A5A5, 1'b0, 3);
    endReq(2);
    checkOutput("cnt_c", {rd_cnt_c, wr_cnt_c}, 32'h0001_0001);

    $display("[TB] dut0: reset while a read response is in flight");
    applyStimulus(0, 1'b0, 32'h08, 4'h0, 32'd0, 4'd10, 32'hDEAD55EF, 1'b0, 1);
    #1;
    checkOutput("rvalid_before_reset", {31'd0, bus_a.rvalid}, 32'd1);
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 4'd0);
    #1;
    checkOutput("rvalid_in_reset", {31'd0, bus_a.rvalid}, 32'd0);
    checkOutput("cnt_a_in_reset", {rd_cnt_a, wr_cnt_a}, 32'd0);
    q_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1'b0, 32'h08, 4'h0, 32'd0, 4'd11, 32'hDEAD55EF, 1'b0, 1);
    endReq(0);
    checkOutput("cnt_a_after_reset", {rd_cnt_a, wr_cnt_a}, 32'h0001_0000);

    repeat (3) @(negedge clk);
    checkOutput("pending_responses", 32'(q_a.size() + q_b.size() + q_c.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/obi_frame_mem.md
Name: obi_frame_mem

Overview:
- OBI subordinate (responder) frame memory that serves pixel reads and result writes from an OBI manager, e.g. the user-domain edge-detection accelerator.
- Attached to the user-domain crossbar on a subordinate port.
- Flop-based word array with byte-enable writes and programmable wait-state insertion, so managers are exercised against non-zero grant latency.
- Saturating read/write access counters for bandwidth debug.

Parameters:
- NumWords, 64, number of 32-bit words stored (power of two, ≥4).
- WaitCycles, 1, cycles of req held low-granted before gnt is issued (0..15).
- CntWidth, 16, width of the access counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- obi_req_i  in  sbr_obi_req_t  OBI request: req, a.addr, a.we, a.be, a.wdata, a.aid.
- obi_rsp_o  out  sbr_obi_rsp_t  OBI response: gnt, rvalid, r.rdata, r.rid, r.err.
- rd_cnt_o  out  CntWidth  number of granted reads, saturating.
- wr_cnt_o  out  CntWidth  number of granted writes, saturating.
- busy_o  out  1  high while a request is pending or a response is in flight.

Behaviour:
- One clock: clk_i. Reset: rst_ni, asynchronous, active-low.
- Reset values:
  - gnt=0, rvalid=0, rdata=0, rid=0, err=0.
  - rd_cnt_o=0, wr_cnt_o=0, busy_o=0.
  - Wait counter=0, FSM=IDLE.
  - Memory contents are not reset. The bench preloads or writes before reading.
- Address decode: byte address. Word index = a.addr[2 +: $clog2(NumWords)]. a.addr[1:0] is ignored.
- FSM states (2-bit enum):
  - IDLE: no req. On req with WaitCycles==0 → gnt same cycle, stay IDLE. On req with WaitCycles>0 → STALL, wait_cnt=1.
  - STALL: gnt=0. wait_cnt increments each cycle while req=1. When wait_cnt==WaitCycles → GRANT.
  - GRANT: gnt=req, combinational. On gnt → IDLE, wait_cnt=0.
  - req dropping in STALL or GRANT (manager abort) → IDLE, wait_cnt=0, no side effects.
- Back-to-back requests: each new request pays the full WaitCycles penalty. Exception: WaitCycles==0 grants every cycle, giving 1 transfer/cycle.
- On gnt (rising edge where req & gnt):
  - Write: for each b with be[b]=1, mem[idx][8b+:8] ← wdata[8b+:8]. be=0 is a legal no-op write that still gets a response.
  - Read: rdata_q ← mem[idx], sampled before any same-edge write. Only one access per edge, so no conflict.
  - aid latched into rid_q.
- Response timing:
  - rvalid asserted exactly one cycle after gnt, held for one cycle.
  - No rready; the response is always consumed.
  - Write responses: rdata=0, err=0.
  - A read in the cycle immediately after a write to the same word returns the new data.
- rdata/rid hold their value when rvalid=0; the bench must only sample them with rvalid.
- Counters: rd_cnt_o / wr_cnt_o increment on each granted read / write. They saturate at all-ones and do not wrap.
- busy_o = req | rvalid_q.
- Reset mid-transaction: pending grant and in-flight rvalid are dropped immediately; counters clear; memory contents are unchanged.

Optional Feature:
- Macro: OBI_FRAME_MEM_ERR_EN.
- Defined:
  - An access with a.addr[31:2+$clog2(NumWords)] != 0 is out of range.
  - It is granted normally and does not touch memory or the counters.
  - Response: err=1; read rdata=32'hBADCAB1E, write rdata=0.
- Undefined:
  - Upper address bits are ignored; the address aliases modulo NumWords*4.
  - err is tied to 0.

Test Plan:
- WaitCycles=1, reset, then write addr 0x08, wdata 0xDEADBEEF, be 4'hF, aid 3 → gnt on 2nd cycle of req; rvalid next cycle with rid=3, err=0; wr_cnt_o=1.
- Read 0x08 after the above → rdata=0xDEADBEEF one cycle after gnt, rd_cnt_o=1. Then write be=4'b0010, wdata=0x00005500 and read back → 0xDEAD55EF.
- WaitCycles=0, 4 consecutive reads of 0x0,0x4,0x8,0xC (preloaded 1,2,3,4) → gnt every cycle; rvalid on 4 consecutive cycles with rdata 1,2,3,4.
- req raised for 1 cycle then dropped in STALL (WaitCycles=3) → no gnt, no rvalid, counters unchanged, FSM back in IDLE.
- Assert rst_ni=0 in the cycle after a read gnt → rvalid=0 immediately; counters=0; previously written word 0x08 still reads 0xDEAD55EF after reset.
- Error/alias check: with OBI_FRAME_MEM_ERR_EN, read addr 0x100 (NumWords=64) → err=1, rdata=0xBADCAB1E, rd_cnt_o unchanged. Without the macro → aliases to 0x000 and returns 1.
